// File: rtl/recovery_controller_if.sv
// recovery_controller_if: request, register-file and recovery-register signals of the recovery controller
interface recovery_controller_if #(parameter int DW = 32);
   logic          ckpt_req;
   logic          rb_req;
   logic [4:0]    rf_ra;
   logic [DW-1:0] rf_rd;
   logic          rec_we;
   logic [31:0]   rec_a;
   logic [DW-1:0] rec_wd;
   logic [DW-1:0] rec_rd;
   logic          rf_we;
   logic [4:0]    rf_wa;
   logic [DW-1:0] rf_wd;
   logic          stall;
   logic          busy;
   logic          done;
   logic          err;
   logic          ckpt_valid;
   modport slave (
      input  ckpt_req, rb_req, rf_rd, rec_rd,
      output rf_ra, rec_we, rec_a, rec_wd, rf_we, rf_wa, rf_wd, stall, busy, done, err, ckpt_valid
   );
   modport master (
      output ckpt_req, rb_req, rf_rd, rec_rd,
      input  rf_ra, rec_we, rec_a, rec_wd, rf_we, rf_wa, rf_wd, stall, busy, done, err, ckpt_valid
   );
endinterface

// File: rtl/recovery_controller.sv
// recovery_controller: checkpoints the voted RF into the recovery register and rolls it back into all replicas.
// Optional RECOVERY_VERIFY_EN adds a read-back VERIFY pass after each rollback.
module recovery_controller #(
   parameter int DW   = 32,
   parameter int NREG = 32
) (
   input logic                  clk,
   input logic                  rst_in,
   recovery_controller_if.slave bus
);
`ifdef RECOVERY_VERIFY_EN
   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, VERIFY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;
`endif
   localparam logic [4:0] LAST = 5'(NREG - 1);
   state_t     r_state, w_state;
   logic [4:0] r_idx, w_idx;
   logic       r_valid, w_valid;
   logic       r_done, w_done;
   logic       r_err, w_err;
   logic       w_save, w_rest, w_ver;
`ifdef RECOVERY_VERIFY_EN
   logic       r_vfail, w_vfail;
`endif
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
`ifdef RECOVERY_VERIFY_EN
         r_vfail <= 1'b0;
`endif
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_valid <= w_valid;
         r_done  <= w_done;
         r_err   <= w_err;
`ifdef RECOVERY_VERIFY_EN
         r_vfail <= w_vfail;
`endif
      end
   end
   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_valid = r_valid;
      w_done  = 1'b0;
      w_err   = 1'b0;
`ifdef RECOVERY_VERIFY_EN
      w_vfail = r_vfail;
`endif
      case (r_state)
         IDLE: begin
            if (bus.rb_req) begin
               w_state = r_valid ? RESTORE : IDLE;
               w_err   = !r_valid;
               w_idx   = '0;
            end else if (bus.ckpt_req) begin
               w_state = SAVE;
               w_idx   = '0;
               w_valid = 1'b0;
            end
         end
         SAVE: begin
            if (bus.rb_req) begin
               w_state = IDLE;
               w_idx   = '0;
               w_err   = 1'b1;
            end else if (r_idx == LAST) begin
               w_state = IDLE;
               w_idx   = '0;
               w_valid = 1'b1;
               w_done  = 1'b1;
            end else
               w_idx = r_idx + 5'd1;
         end
         RESTORE: begin
            if (r_idx == LAST) begin
               w_idx = '0;
`ifdef RECOVERY_VERIFY_EN
               w_state = VERIFY;
               w_vfail = 1'b0;
`else
               w_state = IDLE;
               w_done  = 1'b1;
`endif
            end else
               w_idx = r_idx + 5'd1;
         end
`ifdef RECOVERY_VERIFY_EN
         VERIFY: begin
            // x0 is hardwired in the replicas, so its contents are not compared
            w_vfail = r_vfail | ((r_idx != 5'd0) && (bus.rf_rd != bus.rec_rd));
            if (r_idx == LAST) begin
               w_state = IDLE;
               w_idx   = '0;
               w_done  = 1'b1;
               w_err   = w_vfail;
            end else
               w_idx = r_idx + 5'd1;
         end
`endif
         default: w_state = IDLE;
      endcase
   end
   assign w_save = (r_state == SAVE);
   assign w_rest = (r_state == RESTORE);
`ifdef RECOVERY_VERIFY_EN
   assign w_ver = (r_state == VERIFY);
`else
   assign w_ver = 1'b0;
`endif
   assign bus.rf_ra      = (w_save | w_ver) ? r_idx : 5'd0;
   assign bus.rec_we     = w_save;
   assign bus.rec_a      = (w_save | w_rest | w_ver) ? {27'd0, r_idx} : 32'd0;
   assign bus.rec_wd     = w_save ? bus.rf_rd : {DW{1'b0}};
   assign bus.rf_we      = w_rest && (r_idx != 5'd0);
   assign bus.rf_wa      = w_rest ? r_idx : 5'd0;
   assign bus.rf_wd      = w_rest ? bus.rec_rd : {DW{1'b0}};
   assign bus.busy       = (r_state != IDLE);
   assign bus.stall      = bus.busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.ckpt_valid = r_valid;
endmodule

// File: tb/tb_recovery_controller.sv
// tb_recovery_controller: directed tests of checkpoint, rollback, priority, abort and reset for recovery_controller.
module tb_recovery_controller;
`ifdef RECOVERY_VERIFY_EN
   localparam int RB_CYC = 64;
`else
   localparam int RB_CYC = 32;
`endif
   logic clk = 1'b0;
   logic rst_in = 1'b0;
   logic [31:0] rf [32];
   logic [31:0] rec [32];
   logic pk_en = 1'b0;
   logic [4:0] pk_a = '0;
   logic [31:0] pk_d = '0;
   logic inj = 1'b0;
   int rec_we_cnt = 0, rf_we_cnt = 0, rf_we0_cnt = 0;
   int tests = 0, fails = 0;
   recovery_controller_if #(.DW(32)) bus ();
   recovery_controller #(.DW(32), .NREG(32)) dut (.clk(clk), .rst_in(rst_in), .bus(bus.slave));
   always #5 clk = ~clk;
   assign bus.rf_rd  = (inj && bus.rf_ra == 5'd3) ? ~rf[bus.rf_ra] : rf[bus.rf_ra];
   assign bus.rec_rd = rec[bus.rec_a[4:0]];
   always @(posedge clk) begin
      if (pk_en) rf[pk_a] <= pk_d;
      else if (bus.rf_we) rf[bus.rf_wa] <= bus.rf_wd;
      if (bus.rec_we) rec[bus.rec_a[4:0]] <= bus.rec_wd;
      rec_we_cnt <= rec_we_cnt + int'(bus.rec_we);
      rf_we_cnt  <= rf_we_cnt + int'(bus.rf_we);
      rf_we0_cnt <= rf_we0_cnt + int'(bus.rf_we && bus.rf_wa == 5'd0);
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask
   task automatic poke(input logic [4:0] a, input logic [31:0] d);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(negedge clk);
      pk_en = 1'b0;
   endtask
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask
   task automatic pulse_ckpt(input logic rb);
      bus.ckpt_req = 1'b1; bus.rb_req = rb;
      @(negedge clk);
      bus.ckpt_req = 1'b0; bus.rb_req = 1'b0;
   endtask
   task automatic pulse_rb();
      bus.rb_req = 1'b1;
      @(negedge clk);
      bus.rb_req = 1'b0;
   endtask
   task automatic test_reset();
      repeat (3) @(negedge clk);
      chk("reset_flags", {25'd0, bus.busy, bus.stall, bus.done, bus.err, bus.ckpt_valid, bus.rec_we, bus.rf_we}, 32'd0);
      chk("reset_rec_a", bus.rec_a, 32'd0);
      chk("reset_addrs", {22'd0, bus.rf_ra, bus.rf_wa}, 32'd0);
      chk("reset_rf_wd", bus.rf_wd, 32'd0);
      rst_in = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_rb_no_ckpt();
      int w0 = rec_we_cnt, f0 = rf_we_cnt;
      pulse_rb();
      chk("rbnc_err", {31'd0, bus.err}, 32'd1);
      chk("rbnc_busy", {31'd0, bus.busy}, 32'd0);
      chk("rbnc_valid", {31'd0, bus.ckpt_valid}, 32'd0);
      @(negedge clk);
      chk("rbnc_err_once", {31'd0, bus.err}, 32'd0);
      chk("rbnc_writes", 32'(rec_we_cnt - w0 + rf_we_cnt - f0), 32'd0);
   endtask
   task automatic test_checkpoint();
      int n, bad = 0, w0;
      for (int i = 0; i < 32; i++) poke(5'(i), 32'h1000 + 32'(i));
      w0 = rec_we_cnt;
      pulse_ckpt(1'b0);
      chk("ck_first_a", bus.rec_a, 32'd0);
      chk("ck_first_wd", bus.rec_wd, 32'h1000);
      chk("ck_valid_clr", {31'd0, bus.ckpt_valid}, 32'd0);
      wait_idle(n);
      chk("ck_busy_cycles", 32'(n), 32'd32);
      chk("ck_done", {31'd0, bus.done}, 32'd1);
      chk("ck_valid", {31'd0, bus.ckpt_valid}, 32'd1);
      chk("ck_writes", 32'(rec_we_cnt - w0), 32'd32);
      for (int i = 0; i < 32; i++) if (rec[i] !== 32'h1000 + 32'(i)) bad++;
      chk("ck_contents_bad", 32'(bad), 32'd0);
      @(negedge clk);
      chk("ck_done_once", {31'd0, bus.done}, 32'd0);
   endtask
   task automatic test_rollback();
      int n, f0, z0;
      poke(5'd5, 32'hDEAD);
      f0 = rf_we_cnt; z0 = rf_we0_cnt;
      pulse_rb();
      chk("rb_first_we", {31'd0, bus.rf_we}, 32'd0);
      wait_idle(n);
      chk("rb_busy_cycles", 32'(n), 32'(RB_CYC));
      chk("rb_done", {31'd0, bus.done}, 32'd1);
      chk("rb_no_err", {31'd0, bus.err}, 32'd0);
      chk("rb_we_count", 32'(rf_we_cnt - f0), 32'd31);
      chk("rb_we_x0", 32'(rf_we0_cnt - z0), 32'd0);
      chk("rb_x5", rf[5], 32'h1005);
      chk("rb_valid", {31'd0, bus.ckpt_valid}, 32'd1);
      @(negedge clk);
   endtask
   task automatic test_priority();
      int n, w0, f0;
      poke(5'd9, 32'hBEEF);
      w0 = rec_we_cnt; f0 = rf_we_cnt;
      pulse_ckpt(1'b1);
      wait_idle(n);
      chk("pri_busy_cycles", 32'(n), 32'(RB_CYC));
      chk("pri_no_save", 32'(rec_we_cnt - w0), 32'd0);
      chk("pri_restores", 32'(rf_we_cnt - f0), 32'd31);
      chk("pri_x9", rf[9], 32'h1009);
      chk("pri_valid", {31'd0, bus.ckpt_valid}, 32'd1);
      @(negedge clk);
   endtask
   task automatic test_abort();
      int w0 = rec_we_cnt;
      pulse_ckpt(1'b0);
      repeat (10) @(negedge clk);
      chk("ab_idx10", bus.rec_a, 32'd10);
      bus.rb_req = 1'b1;
      @(negedge clk);
      bus.rb_req = 1'b0;
      chk("ab_busy", {31'd0, bus.busy}, 32'd0);
      chk("ab_err", {31'd0, bus.err}, 32'd1);
      chk("ab_valid", {31'd0, bus.ckpt_valid}, 32'd0);
      repeat (3) @(negedge clk);
      chk("ab_writes", 32'(rec_we_cnt - w0), 32'd11);
      chk("ab_err_once", {31'd0, bus.err}, 32'd0);
   endtask
   task automatic test_reset_mid_restore();
      int n;
      for (int i = 0; i < 32; i++) poke(5'(i), 32'h1000 + 32'(i));
      pulse_ckpt(1'b0);
      wait_idle(n);
      chk("mr_ckpt_valid", {31'd0, bus.ckpt_valid}, 32'd1);
      @(negedge clk);
      pulse_rb();
      repeat (7) @(negedge clk);
      chk("mr_idx7", {27'd0, bus.rf_wa}, 32'd7);
      rst_in = 1'b0;
      #1;
      chk("mr_strobes", {28'd0, bus.rf_we, bus.rec_we, bus.busy, bus.done}, 32'd0);
      chk("mr_addr", {27'd0, bus.rf_wa}, 32'd0);
      chk("mr_valid", {31'd0, bus.ckpt_valid}, 32'd0);
      @(negedge clk);
      chk("mr_no_done", {31'd0, bus.done}, 32'd0);
      rst_in = 1'b1;
      @(negedge clk);
   endtask
`ifdef RECOVERY_VERIFY_EN
   task automatic test_verify_mismatch();
      int n;
      for (int i = 0; i < 32; i++) poke(5'(i), 32'h2000 + 32'(i));
      pulse_ckpt(1'b0);
      wait_idle(n);
      @(negedge clk);
      inj = 1'b1;
      pulse_rb();
      wait_idle(n);
      inj = 1'b0;
      chk("vf_busy_cycles", 32'(n), 32'd64);
      chk("vf_done_err", {30'd0, bus.done, bus.err}, 32'd3);
      @(negedge clk);
      chk("vf_pulse_once", {30'd0, bus.done, bus.err}, 32'd0);
   endtask
`endif
   initial begin
      bus.ckpt_req = 1'b0;
      bus.rb_req   = 1'b0;
      test_reset();
      test_rb_no_ckpt();
      test_checkpoint();
      test_rollback();
      test_priority();
      test_abort();
      test_reset_mid_restore();
`ifdef RECOVERY_VERIFY_EN
      test_verify_mismatch();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
